// File: rtl/moving_average_param.sv
// moving_average_param: strobe-driven moving-average filter with a run-time
// selectable power-of-two window, optional round-half-up, buffer flush on
// window change, settled flag and dropped-strobe reporting.
module moving_average_param #(
    parameter int DATA_W      = 10,
    parameter int LOG2_MAX    = 3,
    parameter int DEFAULT_WIN = 1,
    parameter int ROUND       = 1,
    localparam int WSEL_W     = $clog2(LOG2_MAX + 1),
    localparam int ACC_W      = DATA_W + LOG2_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe_in,
    input  logic [WSEL_W-1:0] win_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              busy,
    output logic              settled,
    output logic              drop
);

    localparam int MAX_DEPTH = 1 << LOG2_MAX;
    localparam int PTR_W     = LOG2_MAX;
    localparam int CNT_W     = LOG2_MAX + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WSEL_W-1:0]   k_act_r;
    logic [WSEL_W-1:0]   k_req_s;
    logic [ACC_W-1:0]    acc_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    clr_cnt_r;
    logic [CNT_W-1:0]    fill_r;
    logic [DATA_W-1:0]   mem_r [MAX_DEPTH];

    logic                accept_s;
    logic                drop_s;
    logic                enter_clear_s;
    logic [CNT_W-1:0]    n_s;
    logic [PTR_W-1:0]    rd_idx_s;
    logic [DATA_W-1:0]   old_s;
    logic [ACC_W-1:0]    acc_new_s;
    logic [ACC_W-1:0]    round_s;
    logic [ACC_W-1:0]    avg_s;
    logic [CNT_W-1:0]    fill_nxt_s;

    // Requested window exponents beyond the buffer depth fall back to the maximum.
    function automatic logic [WSEL_W-1:0] clamp_win(input logic [WSEL_W-1:0] sel);
        if (int'(sel) > LOG2_MAX) begin
            clamp_win = WSEL_W'(LOG2_MAX);
        end else begin
            clamp_win = sel;
        end
    endfunction

    // Datapath: sample leaving the window, new running sum, rounded average, next fill level.
    always_comb begin
        k_req_s   = clamp_win(win_sel);
        n_s       = CNT_W'(1) << k_act_r;
        // With N == MAX_DEPTH the index wraps to wr_ptr itself: the entry about to be overwritten.
        rd_idx_s  = wr_ptr_r - n_s[PTR_W-1:0];
        old_s     = mem_r[rd_idx_s];
        acc_new_s = acc_r + ACC_W'(data_in) - ACC_W'(old_s);
        if (ROUND != 0) begin
            round_s = (ACC_W'(1) << k_act_r) >> 1;
        end else begin
            round_s = {ACC_W{1'b0}};
        end
        // N*max + N/2 stays below 2^ACC_W, so the sum cannot wrap and the result fits DATA_W.
        avg_s = (acc_new_s + round_s) >> k_act_r;
        if (fill_r != n_s) begin
            fill_nxt_s = fill_r + CNT_W'(1);
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Next-state logic: a window change beats a simultaneous strobe; CLEAR runs a fixed length.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (k_req_s != k_act_r) begin
                    state_nxt_s = ST_CLEAR;
                    drop_s      = strobe_in;
                end else begin
                    accept_s    = strobe_in;
                end
            end
            ST_CLEAR: begin
                drop_s = strobe_in;
                if (clr_cnt_r == PTR_W'(MAX_DEPTH - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
        enter_clear_s = (state_r == ST_RUN) && (state_nxt_s == ST_CLEAR);
    end

    // Control and datapath registers plus all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            k_act_r    <= WSEL_W'(DEFAULT_WIN);
            acc_r      <= {ACC_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            clr_cnt_r  <= {PTR_W{1'b0}};
            fill_r     <= {CNT_W{1'b0}};
            data_out   <= {DATA_W{1'b0}};
            strobe_out <= 1'b0;
            busy       <= 1'b0;
            settled    <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            strobe_out <= accept_s;
            drop       <= drop_s;
            busy       <= (state_nxt_s == ST_CLEAR);
            if (enter_clear_s) begin
                k_act_r   <= k_req_s;
                acc_r     <= {ACC_W{1'b0}};
                wr_ptr_r  <= {PTR_W{1'b0}};
                clr_cnt_r <= {PTR_W{1'b0}};
                fill_r    <= {CNT_W{1'b0}};
                settled   <= 1'b0;
            end else if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + PTR_W'(1);
            end else if (accept_s) begin
                acc_r    <= acc_new_s;
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                fill_r   <= fill_nxt_s;
                settled  <= (fill_nxt_s == n_s);
                data_out <= DATA_W'(avg_s);
            end
        end
    end

    // Sample history: written on accepted strobes, zeroed one entry per cycle during CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

endmodule

// File: tb/tb_moving_average_param.sv
// tb_moving_average_param: directed and randomized checks of the moving-average
// filter against a queue-based reference model (mean of the last N samples,
// missing history counted as zero, rounded half up).
module tb_moving_average_param;

    localparam int DATA_W   = 10;
    localparam int LOG2_MAX = 3;
    localparam int WSEL_W   = 2;
    localparam int MAXD     = 8;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              strobe_in;
    logic [WSEL_W-1:0] win_sel;
    logic [DATA_W-1:0] data_out;
    logic              strobe_out;
    logic              busy;
    logic              settled;
    logic              drop;

    int n_checks;
    int n_fail;
    int hist[$];
    int k_model;
    int last_out;

    moving_average_param #(
        .DATA_W(DATA_W), .LOG2_MAX(LOG2_MAX), .DEFAULT_WIN(1), .ROUND(1)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .strobe_in(strobe_in),
        .win_sel(win_sel), .data_out(data_out), .strobe_out(strobe_out),
        .busy(busy), .settled(settled), .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mean of the last 2^k accepted samples (zeros where history is short), round half up.
    function automatic int model_avg();
        int n;
        longint sum;
        int r;
        n = 1 << k_model;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            if (hist.size() > i) sum += hist[hist.size() - 1 - i];
        end
        r = (k_model > 0) ? (1 << (k_model - 1)) : 0;
        return int'((sum + r) / n);
    endfunction

    function automatic bit model_settled();
        return hist.size() >= (1 << k_model);
    endfunction

    // Drive one strobe and leave time just after the capturing edge for the caller to sample.
    task automatic do_strobe(input int v);
        @(negedge clk);
        data_in = DATA_W'(v);
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
        hist.push_back(v);
        if (hist.size() > MAXD) void'(hist.pop_front());
    endtask

    // Request a new window and wait (bounded) for the flush to start and finish.
    task automatic set_window(input int k, output bit ok);
        bit rose;
        rose = 1'b0;
        @(negedge clk);
        win_sel = WSEL_W'(k);
        hist.delete();
        k_model = k;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                rose = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        ok = rose && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        strobe_in = 1'b0;
        data_in = '0;
        win_sel = 2'd1;
        k_model = 1;
        hist.delete();
        last_out = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 10'd0) begin n_fail++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
        n_checks++; if (strobe_out !== 1'b0) begin n_fail++; $display("FAIL reset_strobe_out: got %0b expected 0", strobe_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %0b expected 0", settled); end
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b expected 0", drop); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_flush_default_win: got %0b expected 0", busy); end
    endtask

    task automatic test_impulse();
        bit ok;
        int exp;
        int cnt256;
        int v;
        cnt256 = 0;
        set_window(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL impulse_flush: busy did not complete, busy=%0b", busy); end
        for (int i = 0; i < 21; i++) begin
            v = (i == 10) ? 1023 : 0;
            do_strobe(v);
            exp = model_avg();
            if (exp == 256) cnt256++;
            n_checks++; if (strobe_out !== 1'b1 || data_out !== DATA_W'(exp)) begin
                n_fail++; $display("FAIL impulse_out[%0d]: got %0d/%0b expected %0d/1", i, data_out, strobe_out, exp); end
            n_checks++; if (settled !== model_settled()) begin
                n_fail++; $display("FAIL impulse_settled[%0d]: got %0b expected %0b", i, settled, model_settled()); end
            last_out = exp;
            // an idle cycle between strobes: output must hold and not pulse
            @(posedge clk);
            #1;
            n_checks++; if (strobe_out !== 1'b0 || data_out !== DATA_W'(last_out)) begin
                n_fail++; $display("FAIL impulse_hold[%0d]: got %0d/%0b expected %0d/0", i, data_out, strobe_out, last_out); end
        end
        n_checks++; if (cnt256 != 4) begin n_fail++; $display("FAIL impulse_count256: got %0d expected 4", cnt256); end
    endtask

    task automatic test_wrap();
        bit ok;
        int exp;
        set_window(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_flush: busy did not complete, busy=%0b", busy); end
        for (int i = 1; i <= 20; i++) begin
            do_strobe(i);
            exp = model_avg();
            n_checks++; if (strobe_out !== 1'b1 || data_out !== DATA_W'(exp)) begin
                n_fail++; $display("FAIL wrap_out[%0d]: got %0d/%0b expected %0d/1", i, data_out, strobe_out, exp); end
            last_out = exp;
        end
        n_checks++; if (data_out !== 10'd17) begin n_fail++; $display("FAIL wrap_final: got %0d expected 17", data_out); end
    endtask

    task automatic test_step();
        bit ok;
        int exp;
        set_window(0, ok);
        set_window(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL step_flush: busy did not complete, busy=%0b", busy); end
        for (int i = 0; i < 11; i++) begin
            do_strobe(100);
            exp = model_avg();
            n_checks++; if (strobe_out !== 1'b1 || data_out !== DATA_W'(exp)) begin
                n_fail++; $display("FAIL step_out[%0d]: got %0d/%0b expected %0d/1", i, data_out, strobe_out, exp); end
            n_checks++; if (settled !== model_settled()) begin
                n_fail++; $display("FAIL step_settled[%0d]: got %0b expected %0b", i, settled, model_settled()); end
            last_out = exp;
        end
    endtask

    task automatic test_window_change();
        bit ok;
        int exp;
        int nbusy;
        int ndrop;
        int nstb;
        bit held;
        set_window(1, ok);
        for (int i = 0; i < 4; i++) begin
            do_strobe(500);
            exp = model_avg();
            n_checks++; if (data_out !== DATA_W'(exp)) begin
                n_fail++; $display("FAIL winchg_steady[%0d]: got %0d expected %0d", i, data_out, exp); end
            last_out = exp;
        end
        nbusy = 0; ndrop = 0; nstb = 0; held = 1'b1;
        @(negedge clk);
        win_sel = 2'd3;
        hist.delete();
        k_model = 3;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (busy) nbusy++;
            if (drop) ndrop++;
            if (strobe_out) nstb++;
            if (data_out !== DATA_W'(last_out)) held = 1'b0;
            @(negedge clk);
            strobe_in = (i == 2 || i == 4) ? 1'b1 : 1'b0;
            data_in = 10'd500;
        end
        n_checks++; if (nbusy != 8) begin n_fail++; $display("FAIL winchg_busy_len: got %0d expected 8", nbusy); end
        n_checks++; if (ndrop != 2) begin n_fail++; $display("FAIL winchg_drops: got %0d expected 2", ndrop); end
        n_checks++; if (nstb != 0) begin n_fail++; $display("FAIL winchg_strobe_out: got %0d expected 0", nstb); end
        n_checks++; if (!held) begin n_fail++; $display("FAIL winchg_hold: got %0d expected %0d held", data_out, last_out); end
        do_strobe(500);
        exp = model_avg();
        n_checks++; if (data_out !== DATA_W'(exp) || strobe_out !== 1'b1) begin
            n_fail++; $display("FAIL winchg_first: got %0d expected %0d", data_out, exp); end
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL winchg_settled: got %0b expected 0", settled); end
        last_out = exp;
    endtask

    task automatic test_simultaneous();
        int exp;
        // same window as active: strobe accepted, no flush
        do_strobe(300);
        exp = model_avg();
        n_checks++; if (strobe_out !== 1'b1 || drop !== 1'b0 || busy !== 1'b0 || data_out !== DATA_W'(exp)) begin
            n_fail++; $display("FAIL simul_same_win: got %0d/%0b/%0b/%0b expected %0d/1/0/0", data_out, strobe_out, drop, busy, exp); end
        last_out = exp;
        @(negedge clk);
        win_sel = 2'd2;
        data_in = 10'd700;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
        hist.delete();
        k_model = 2;
        n_checks++; if (drop !== 1'b1 || strobe_out !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL simul_change: got drop=%0b strobe_out=%0b busy=%0b expected 1/0/1", drop, strobe_out, busy); end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_flush_end: got busy=%0b expected 0", busy); end
        do_strobe(400);
        exp = model_avg();
        n_checks++; if (data_out !== DATA_W'(exp) || strobe_out !== 1'b1) begin
            n_fail++; $display("FAIL simul_after: got %0d expected %0d", data_out, exp); end
        last_out = exp;
    endtask

    task automatic test_async_reset();
        int exp;
        do_strobe(800);
        @(negedge clk);
        data_in = 10'd900;
        strobe_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (data_out !== 10'd0 || strobe_out !== 1'b0 || settled !== 1'b0 || busy !== 1'b0 || drop !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate: got %0d/%0b/%0b/%0b/%0b expected all 0", data_out, strobe_out, settled, busy, drop); end
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
        n_checks++; if (strobe_out !== 1'b0) begin n_fail++; $display("FAIL areset_no_inflight: got %0b expected 0", strobe_out); end
        win_sel = 2'd1;
        hist.delete();
        k_model = 1;
        @(negedge clk);
        rst = 1'b0;
        do_strobe(1023);
        exp = model_avg();
        n_checks++; if (data_out !== DATA_W'(exp) || strobe_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL areset_first: got %0d/%0b/%0b expected %0d/1/0", data_out, strobe_out, busy, exp); end
        n_checks++; if (data_out !== 10'd512) begin n_fail++; $display("FAIL areset_512: got %0d expected 512", data_out); end
        last_out = exp;
    endtask

    task automatic test_random();
        bit ok;
        int k;
        int exp;
        int v;
        bit s;
        for (int r = 0; r < 6; r++) begin
            k = (k_model + 1 + int'($urandom_range(0, 2))) % 4;
            set_window(k, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_flush[%0d]: busy did not complete", r); end
            for (int c = 0; c < 30; c++) begin
                s = 1'($urandom_range(0, 1));
                if (s) begin
                    v = int'($urandom_range(0, 1023));
                    do_strobe(v);
                    exp = model_avg();
                    n_checks++; if (strobe_out !== 1'b1 || data_out !== DATA_W'(exp) || settled !== model_settled() || drop !== 1'b0) begin
                        n_fail++; $display("FAIL rand_out[%0d/%0d]: got %0d/%0b/%0b expected %0d/1/%0b", r, c, data_out, strobe_out, settled, exp, model_settled()); end
                    last_out = exp;
                end else begin
                    @(posedge clk);
                    #1;
                    n_checks++; if (strobe_out !== 1'b0 || data_out !== DATA_W'(last_out)) begin
                        n_fail++; $display("FAIL rand_idle[%0d/%0d]: got %0d/%0b expected %0d/0", r, c, data_out, strobe_out, last_out); end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_impulse();
        test_wrap();
        test_window_change();
        test_step();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
